// File: rtl/out_pixel_writer_pkg.sv
// Shared types and pixel conversion for the output pixel write-back stage.
// PIX_SATURATE_EN selects signed clamping instead of plain truncation in to_pixel().
package out_pix_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} opw_state_t;

  localparam int PIX_W = 8;
  localparam int RES_W = 32;

  function automatic logic [PIX_W-1:0] to_pixel(input logic signed [RES_W-1:0] res);
`ifdef PIX_SATURATE_EN
    if (res < 0)
      return '0;
    else if (res > 255)
      return '1;
    else
      return res[PIX_W-1:0];
`else
    return res[PIX_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/out_pixel_writer_if.sv
// Result-word input handshake and pixel memory write port of out_pixel_writer.
interface out_pixel_writer_if #(
  parameter int ADDR_W = 16
);
  import out_pix_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_data;
  logic             mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/out_pixel_writer_fifo.sv
// Synchronous FIFO (module pix_fifo) buffering result words ahead of pixel conversion.
// Read data is combinational from the head entry; pointers carry an extra wrap bit.
module pix_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/out_pixel_writer.sv
// Write-back stage: buffers result words, converts each to a pixel and writes NUM_PIX
// pixels sequentially from address 0. Conversion mode follows PIX_SATURATE_EN.
module out_pixel_writer
  import out_pix_pkg::*;
#(
  parameter int NUM_PIX    = 51200,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  out_pixel_writer_if.slave   bus,
  output logic                busy,
  output logic                frame_done,
  output logic [ADDR_W:0]     pix_count
);

  localparam logic [ADDR_W:0]   PIX_TOTAL = (ADDR_W+1)'(NUM_PIX);
  localparam logic [ADDR_W:0]   PIX_LAST  = (ADDR_W+1)'(NUM_PIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PIX - 1);

  opw_state_t state, state_nxt;

  logic [ADDR_W:0]  accepted;
  logic             fifo_full, fifo_empty;
  logic [RES_W-1:0] fifo_rd;
  logic             push, pop, start_frame, issue, last_wr;

  logic [RES_W-1:0] data_p0;
  logic             vld_p0;

  pix_fifo #(
    .W     (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (bus.in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = RUN;
      RUN:     if (last_wr) state_nxt = DONE;
      DONE:    if (start)   state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO refuses input even while it is being popped: no pass-through path.
  always_comb begin
    busy         = (state == RUN);
    bus.in_ready = (state == RUN) && !fifo_full && (accepted < PIX_TOTAL);
    start_frame  = start && (state != RUN);
    push         = bus.in_valid && bus.in_ready;
    issue        = vld_p0 && (state == RUN);
    last_wr      = issue && (pix_count == PIX_LAST);
  end

  assign pop = (state == RUN) && !fifo_empty;

  // Stage p0: word popped from the FIFO
  always_ff @(posedge clk) begin
    if (rst)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= pop;
  end

  always_ff @(posedge clk) begin
    if (pop)
      data_p0 <= fifo_rd;
  end

  // Output stage: registered memory write, counters and frame-done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      accepted      <= '0;
      pix_count     <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      frame_done    <= 1'b0;
    end else begin
      bus.mem_we <= issue;
      frame_done <= bus.mem_we && (bus.mem_addr == ADDR_LAST);
      if (issue) begin
        bus.mem_addr  <= pix_count[ADDR_W-1:0];
        bus.mem_wdata <= to_pixel($signed(data_p0));
      end
      if (start_frame) begin
        accepted  <= '0;
        pix_count <= '0;
      end else begin
        if (push)
          accepted <= accepted + 1'b1;
        if (issue)
          pix_count <= pix_count + 1'b1;
      end
    end
  end

endmodule
